if_stage: RTL



---
 rtl/if_pkg.sv | 23 ++
 rtl/if_stage_if.sv | 11 +
 rtl/if_perf_cnt.sv | 25 ++
 rtl/if_stage.sv | 101 ++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants for the RISC-TOY fetch stage and later stage registers
package if_pkg;

    localparam int          PC_W_DEF     = 30;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Bubble contents of a stage register: no-op word, not valid
    typedef struct packed {
        logic [31:0] inst;
        logic        valid;
    } stage_slot_t;

    localparam stage_slot_t BUBBLE_SLOT = '{inst: NOP_INST_DEF, valid: 1'b0};

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic [PC_W_DEF-1:0] pc_inc(input logic [PC_W_DEF-1:0] pc);
        return pc + PC_W_DEF'(1);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory read port between the fetch stage and memory
interface if_stage_if #(
    parameter int PC_W = 30
);
    logic            IREQ;
    logic [PC_W-1:0] IADDR;
    logic [31:0]     INSTR;

    modport master (output IREQ, output IADDR, input INSTR);
    modport slave  (input IREQ, input IADDR, output INSTR);
endinterface

// File: rtl/if_perf_cnt.sv
// rtl/if_perf_cnt.sv - saturating fetch/stall/flush event counters for the fetch stage
module if_perf_cnt (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        fetch_ev,
    input  logic        stall_ev,
    input  logic        flush_ev,
    output logic [31:0] FETCH_CNT,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            FETCH_CNT <= '0;
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (fetch_ev && FETCH_CNT != '1) FETCH_CNT <= FETCH_CNT + 32'd1;
            if (stall_ev && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 32'd1;
            if (flush_ev && FLUSH_CNT != '1) FLUSH_CNT <= FLUSH_CNT + 32'd1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-TOY instruction fetch stage with IF/ID register
// Optional IF_PERF_CNT_EN adds saturating FETCH/STALL/FLUSH counters.
module if_stage
    import if_pkg::*;
#(
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF,
    parameter int          PC_W     = PC_W_DEF
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            Stall,
    input  logic            Branch_Taken,
    input  logic [PC_W-1:0] Branch_Target,
    input  logic            Halt,
    if_stage_if.master      imem,
    output logic [31:0]     INST_IF,
    output logic [31:0]     INST_ID,
    output logic [PC_W-1:0] PC_ID,
    output logic            VALID_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     FETCH_CNT,
    output logic [31:0]     STALL_CNT,
    output logic [31:0]     FLUSH_CNT
`endif
);

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next_seq;
    logic            run;

    assign run         = (state == ST_RUN);
    assign pc_next_seq = pc + PC_W'(1);

    assign imem.IREQ  = run;
    assign imem.IADDR = pc;
    assign INST_IF    = run ? imem.INSTR : NOP_INST;

    // Halt outranks a branch, which outranks a stall; a bubble keeps PC_ID unchanged
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_BOOT;
            pc       <= PC_W'(RESET_PC);
            INST_ID  <= NOP_INST;
            PC_ID    <= '0;
            VALID_ID <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= Halt ? ST_HALTED : ST_RUN;
                    INST_ID  <= NOP_INST;
                    VALID_ID <= 1'b0;
                end
                ST_RUN: begin
                    if (Halt) begin
                        state    <= ST_HALTED;
                        INST_ID  <= NOP_INST;
                        VALID_ID <= 1'b0;
                    end else if (Branch_Taken) begin
                        pc       <= Branch_Target;
                        INST_ID  <= NOP_INST;
                        VALID_ID <= 1'b0;
                    end else if (!Stall) begin
                        pc       <= pc_next_seq;
                        INST_ID  <= imem.INSTR;
                        PC_ID    <= pc_next_seq;
                        VALID_ID <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    INST_ID  <= NOP_INST;
                    VALID_ID <= 1'b0;
                end
                default: begin
                    state    <= ST_BOOT;
                    INST_ID  <= NOP_INST;
                    VALID_ID <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic live;
    assign live = run && !Halt;

    if_perf_cnt u_perf_cnt (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .fetch_ev  (live && !Branch_Taken && !Stall),
        .stall_ev  (live && !Branch_Taken && Stall),
        .flush_ev  (live && Branch_Taken),
        .FETCH_CNT (FETCH_CNT),
        .STALL_CNT (STALL_CNT),
        .FLUSH_CNT (FLUSH_CNT)
    );
`endif

endmodule
